// File: rtl/dmem_arbiter.sv
// -----------------------------------------------------------------------------
// dmem_arbiter
//
// Purpose:
//   Shares one single-ported data memory between two requesters: port A
//   (the core) and port B (a loader/debug agent). It grants one request at a
//   time with a round-robin choice between the ports. Each granted request is
//   checked for RV32I legality and then takes one access cycle. The result is
//   returned as a one-cycle done pulse on the port that made the request.
//
//   Transaction timeline (grant in cycle N):
//     N    IDLE    gnt high (combinational), request latched at the edge
//     N+1  ACCESS  mem_mr / mem_mw strobe (legal requests only)
//     N+2  DONE    done pulse with rdata / err on the owning port
//     N+3  IDLE    earliest next grant
//
// Parameters:
//   MEM_BYTES   byte size of the data memory; addresses >= MEM_BYTES are
//               rejected
//
// Ports:
//   clk, rst_n                 clock, synchronous active-low reset
//   a_req/b_req                access request, held until granted
//   a_we/b_we                  1 = store, 0 = load
//   a_addr/b_addr              byte address
//   a_wdata/b_wdata            store data
//   a_funct3/b_funct3          RV32I load/store width code
//   a_gnt/b_gnt                request accepted this cycle (combinational)
//   a_done/b_done              one-cycle completion pulse (registered)
//   a_rdata/b_rdata            load result, valid while done = 1
//   a_err/b_err                request rejected, valid while done = 1
//   mem_mr, mem_mw             read / write strobes to the data memory
//   mem_address, mem_rd2       address and store data to the data memory
//   mem_funct3                 width code to the data memory
//   mem_rs2_out                combinational read data from the data memory
//   busy                       high whenever the FSM is not idle
// -----------------------------------------------------------------------------
module dmem_arbiter #(
  parameter int unsigned MEM_BYTES = 32768
) (
  input  logic        clk,
  input  logic        rst_n,

  input  logic        a_req,
  input  logic        a_we,
  input  logic [31:0] a_addr,
  input  logic [31:0] a_wdata,
  input  logic [2:0]  a_funct3,
  output logic        a_gnt,
  output logic        a_done,
  output logic [31:0] a_rdata,
  output logic        a_err,

  input  logic        b_req,
  input  logic        b_we,
  input  logic [31:0] b_addr,
  input  logic [31:0] b_wdata,
  input  logic [2:0]  b_funct3,
  output logic        b_gnt,
  output logic        b_done,
  output logic [31:0] b_rdata,
  output logic        b_err,

  output logic        mem_mr,
  output logic        mem_mw,
  output logic [31:0] mem_address,
  output logic [31:0] mem_rd2,
  output logic [2:0]  mem_funct3,
  input  logic [31:0] mem_rs2_out,

  output logic        busy
);

  // ---------------------------------------------------------------------------
  // Constants
  // ---------------------------------------------------------------------------
  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ACCESS = 2'd1;
  localparam logic [1:0] S_DONE   = 2'd2;

  localparam logic [31:0] MEM_LIMIT = 32'(MEM_BYTES);

  // RV32I load/store width codes
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [1:0]  state;
  logic [1:0]  state_next;
  logic        ptr;         // 0: A preferred, 1: B preferred

  logic        lat_we;
  logic [31:0] lat_addr;
  logic [31:0] lat_wdata;
  logic [2:0]  lat_funct3;
  logic        lat_id;      // 0: port A owns the transaction, 1: port B

  logic        done_q;
  logic [31:0] rdata_q;
  logic        err_q;

  logic        grant_any;
  logic        illegal;
  logic        access_ok;

  // ---------------------------------------------------------------------------
  // Arbitration
  // A sole requester always wins. On a tie the pointer decides. No grant is
  // given while reset is asserted, so a request held through reset is only
  // accepted after reset is released.
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every output of this block gets a default first so no path through
    // the branches leaves a value unassigned and infers a latch.
    a_gnt = 1'b0;
    b_gnt = 1'b0;
    if (rst_n && (state == S_IDLE)) begin
      if (a_req && b_req) begin
        a_gnt = ~ptr;
        b_gnt = ptr;
      end else begin
        a_gnt = a_req;
        b_gnt = b_req;
      end
    end
  end

  assign grant_any = a_gnt | b_gnt;

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:   state_next = grant_any ? S_ACCESS : S_IDLE;
      S_ACCESS: state_next = S_DONE;
      S_DONE:   state_next = S_IDLE;
      default:  state_next = S_IDLE;
    endcase
  end

  // NOTE: sequential state is updated with non-blocking assignments so that
  // every register samples the pre-edge value of every other register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= S_IDLE;
      ptr   <= 1'b0;
    end else begin
      state <= state_next;
      // After a grant the other port becomes preferred.
      if (grant_any) begin
        ptr <= a_gnt;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Request latch
  // The requester may change or drop its inputs after the grant. The access
  // is carried out using only these copies.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    // NOTE: the latched request is reset explicitly so that mem_address,
    // mem_rd2 and mem_funct3 leave reset at a known value instead of X.
    if (!rst_n) begin
      lat_we     <= 1'b0;
      lat_addr   <= 32'h0;
      lat_wdata  <= 32'h0;
      lat_funct3 <= 3'b000;
      lat_id     <= 1'b0;
    end else if (grant_any) begin
      lat_we     <= b_gnt ? b_we     : a_we;
      lat_addr   <= b_gnt ? b_addr   : a_addr;
      lat_wdata  <= b_gnt ? b_wdata  : a_wdata;
      lat_funct3 <= b_gnt ? b_funct3 : a_funct3;
      lat_id     <= b_gnt;
    end
  end

  // ---------------------------------------------------------------------------
  // Legality check on the latched request
  // ---------------------------------------------------------------------------
  always_comb begin
    illegal = 1'b0;

    if (lat_addr >= MEM_LIMIT) begin
      illegal = 1'b1;
    end

    // Stores only exist as sb / sh / sw.
    if (lat_we && !(lat_funct3 == F3_B || lat_funct3 == F3_H || lat_funct3 == F3_W)) begin
      illegal = 1'b1;
    end

    // Loads: 011, 110 and 111 are not RV32I load encodings.
    if (!lat_we && !(lat_funct3 == F3_B  || lat_funct3 == F3_H  || lat_funct3 == F3_W ||
                     lat_funct3 == F3_BU || lat_funct3 == F3_HU)) begin
      illegal = 1'b1;
    end

    // Halfword accesses must be 2-byte aligned.
    if ((lat_funct3 == F3_H || lat_funct3 == F3_HU) && lat_addr[0]) begin
      illegal = 1'b1;
    end

    // Word accesses must be 4-byte aligned.
    if ((lat_funct3 == F3_W) && (lat_addr[1:0] != 2'b00)) begin
      illegal = 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Memory interface
  // The strobes are gated with rst_n. A store whose access edge coincides
  // with reset therefore never reaches the memory.
  // ---------------------------------------------------------------------------
  assign access_ok   = rst_n && (state == S_ACCESS) && !illegal;
  assign mem_mr      = access_ok && !lat_we;
  assign mem_mw      = access_ok &&  lat_we;
  assign mem_address = lat_addr;
  assign mem_rd2     = lat_wdata;
  assign mem_funct3  = lat_funct3;

  // ---------------------------------------------------------------------------
  // Result capture
  // The memory's read data is captured at the end of ACCESS. The done pulse
  // lines up with the DONE state.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      done_q  <= 1'b0;
      rdata_q <= 32'h0;
      err_q   <= 1'b0;
    end else if (state == S_ACCESS) begin
      done_q  <= 1'b1;
      rdata_q <= (!illegal && !lat_we) ? mem_rs2_out : 32'h0;
      err_q   <= illegal;
    end else begin
      done_q  <= 1'b0;
    end
  end

  // ---------------------------------------------------------------------------
  // Per-port result steering
  // lat_id cannot change while done_q is high, because grants only happen in
  // IDLE. The non-owning port therefore sees all zeros.
  // ---------------------------------------------------------------------------
  assign a_done  = done_q && !lat_id;
  assign b_done  = done_q &&  lat_id;
  assign a_rdata = a_done ? rdata_q : 32'h0;
  assign b_rdata = b_done ? rdata_q : 32'h0;
  assign a_err   = a_done && err_q;
  assign b_err   = b_done && err_q;

  assign busy    = (state != S_IDLE);

endmodule

// File: tb/tb_dmem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_dmem_arbiter
//
// Directed self-checking bench for dmem_arbiter. The bench provides a
// byte-addressed RV32I data memory model: a combinational read with sign or
// zero extension, and a write on the rising edge when mem_mw is high.
// Each scenario task drives stimulus and compares against hand-computed
// values.
// -----------------------------------------------------------------------------
module tb_dmem_arbiter;

  localparam int unsigned MEM_BYTES = 32768;

  logic        clk = 1'b0;
  logic        rst_n;

  logic        a_req, a_we, b_req, b_we;
  logic [31:0] a_addr, a_wdata, b_addr, b_wdata;
  logic [2:0]  a_funct3, b_funct3;
  logic        a_gnt, a_done, a_err, b_gnt, b_done, b_err;
  logic [31:0] a_rdata, b_rdata;
  logic        mem_mr, mem_mw;
  logic [31:0] mem_address, mem_rd2, mem_rs2_out;
  logic [2:0]  mem_funct3;
  logic        busy;

  int passed = 0;
  int total  = 0;

  int strobe_cnt  = 0;
  int overlap_cnt = 0;

  dmem_arbiter #(.MEM_BYTES(MEM_BYTES)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .a_req       (a_req),
    .a_we        (a_we),
    .a_addr      (a_addr),
    .a_wdata     (a_wdata),
    .a_funct3    (a_funct3),
    .a_gnt       (a_gnt),
    .a_done      (a_done),
    .a_rdata     (a_rdata),
    .a_err       (a_err),
    .b_req       (b_req),
    .b_we        (b_we),
    .b_addr      (b_addr),
    .b_wdata     (b_wdata),
    .b_funct3    (b_funct3),
    .b_gnt       (b_gnt),
    .b_done      (b_done),
    .b_rdata     (b_rdata),
    .b_err       (b_err),
    .mem_mr      (mem_mr),
    .mem_mw      (mem_mw),
    .mem_address (mem_address),
    .mem_rd2     (mem_rd2),
    .mem_funct3  (mem_funct3),
    .mem_rs2_out (mem_rs2_out),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  // ---------------------------------------------------------------------------
  // Data memory model
  // ---------------------------------------------------------------------------
  logic [7:0] mem [0:MEM_BYTES-1];

  initial begin
    for (int i = 0; i < MEM_BYTES; i++) mem[i] = 8'h00;
  end

  always @(posedge clk) begin
    if (mem_mr || mem_mw) strobe_cnt++;
    if (mem_mr && mem_mw) overlap_cnt++;
    if (mem_mw) begin
      case (mem_funct3)
        3'b000: mem[mem_address[14:0]] = mem_rd2[7:0];
        3'b001: begin
          mem[mem_address[14:0]]         = mem_rd2[7:0];
          mem[mem_address[14:0] + 15'd1] = mem_rd2[15:8];
        end
        default: begin
          mem[mem_address[14:0]]         = mem_rd2[7:0];
          mem[mem_address[14:0] + 15'd1] = mem_rd2[15:8];
          mem[mem_address[14:0] + 15'd2] = mem_rd2[23:16];
          mem[mem_address[14:0] + 15'd3] = mem_rd2[31:24];
        end
      endcase
    end
  end

  always_comb begin
    logic [7:0] b0, b1, b2, b3;
    b0 = mem[mem_address[14:0]];
    b1 = mem[mem_address[14:0] + 15'd1];
    b2 = mem[mem_address[14:0] + 15'd2];
    b3 = mem[mem_address[14:0] + 15'd3];
    mem_rs2_out = 32'h0;
    case (mem_funct3)
      3'b000:  mem_rs2_out = {{24{b0[7]}}, b0};
      3'b001:  mem_rs2_out = {{16{b1[7]}}, b1, b0};
      3'b010:  mem_rs2_out = {b3, b2, b1, b0};
      3'b100:  mem_rs2_out = {24'h0, b0};
      3'b101:  mem_rs2_out = {16'h0, b1, b0};
      default: mem_rs2_out = 32'h0;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Single transaction on one port. Returns the observed strobes, done and
  // result; gnt_ok = 0 if no grant appeared within the cycle budget.
  // ---------------------------------------------------------------------------
  task automatic xact(input bit port, input bit we, input logic [31:0] addr,
                      input logic [31:0] wdata, input logic [2:0] f3,
                      output bit gnt_ok, output logic mr, output logic mw,
                      output logic done, output logic err,
                      output logic [31:0] rdata, output logic other_done);
    int waited;
    @(negedge clk);
    if (port) begin
      b_req = 1'b1; b_we = we; b_addr = addr; b_wdata = wdata; b_funct3 = f3;
    end else begin
      a_req = 1'b1; a_we = we; a_addr = addr; a_wdata = wdata; a_funct3 = f3;
    end
    waited = 0;
    #1;
    while (!(port ? b_gnt : a_gnt) && waited < 20) begin
      @(negedge clk); #1; waited++;
    end
    gnt_ok = (waited < 20);
    mr = 1'b0; mw = 1'b0; done = 1'b0; err = 1'b0; rdata = 32'h0; other_done = 1'b0;
    // ACCESS cycle
    @(negedge clk);
    a_req = 1'b0; b_req = 1'b0;
    if (!gnt_ok) return;
    #1;
    mr = mem_mr; mw = mem_mw;
    // DONE cycle
    @(negedge clk); #1;
    done       = port ? b_done  : a_done;
    err        = port ? b_err   : a_err;
    rdata      = port ? b_rdata : a_rdata;
    other_done = port ? a_done  : b_done;
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_reset();
    rst_n = 1'b0;
    a_req = 1'b1; b_req = 1'b1;
    a_we = 1'b0; b_we = 1'b0; a_addr = 32'h0; b_addr = 32'h0;
    a_wdata = 32'h0; b_wdata = 32'h0; a_funct3 = 3'b010; b_funct3 = 3'b010;
    repeat (3) @(negedge clk);
    #1;
    total++;
    if ({a_gnt, b_gnt} !== 2'b00) $display("FAIL reset_gnt: got %b expected 00", {a_gnt, b_gnt});
    else passed++;
    total++;
    if ({busy, a_done, b_done, a_err, b_err, mem_mr, mem_mw} !== 7'b0)
      $display("FAIL reset_flags: got %b expected 0000000",
               {busy, a_done, b_done, a_err, b_err, mem_mr, mem_mw});
    else passed++;
    total++;
    if ({a_rdata, b_rdata} !== 64'h0) $display("FAIL reset_rdata: got %h expected 0", {a_rdata, b_rdata});
    else passed++;
    a_req = 1'b0; b_req = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_store_load();
    bit gnt_ok; logic mr, mw, done, err, od; logic [31:0] rd;
    xact(1'b0, 1'b1, 32'h100, 32'hDEADBEEF, 3'b010, gnt_ok, mr, mw, done, err, rd, od);
    total++;
    if (!gnt_ok) $display("FAIL sw_gnt: no grant expected a_gnt");
    else passed++;
    total++;
    if ({mr, mw} !== 2'b01) $display("FAIL sw_strobe: got %b expected 01", {mr, mw});
    else passed++;
    total++;
    if ({done, err, od} !== 3'b100) $display("FAIL sw_done: got %b expected 100", {done, err, od});
    else passed++;

    xact(1'b0, 1'b0, 32'h100, 32'h0, 3'b010, gnt_ok, mr, mw, done, err, rd, od);
    total++;
    if ({gnt_ok, mr, mw, done, err} !== 5'b11010) $display("FAIL lw_flags: got %b expected 11010", {gnt_ok, mr, mw, done, err});
    else passed++;
    total++;
    if (rd !== 32'hDEADBEEF) $display("FAIL lw_rdata: got %h expected deadbeef", rd);
    else passed++;
  endtask

  task automatic test_simultaneous();
    rst_n = 1'b0;
    a_req = 1'b1; a_we = 1'b0; a_addr = 32'h100; a_funct3 = 3'b010;
    b_req = 1'b1; b_we = 1'b0; b_addr = 32'h100; b_funct3 = 3'b010;
    repeat (2) @(negedge clk);
    #1;
    total++;
    if ({a_gnt, b_gnt} !== 2'b00) $display("FAIL rr_reset_gnt: got %b expected 00", {a_gnt, b_gnt});
    else passed++;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    for (int k = 0; k < 4; k++) begin
      logic [1:0] exp_v;
      exp_v = (k % 2 == 0) ? 2'b10 : 2'b01;
      total++;
      if ({a_gnt, b_gnt} !== exp_v) $display("FAIL rr_gnt_%0d: got %b expected %b", k, {a_gnt, b_gnt}, exp_v);
      else passed++;
      @(negedge clk); #1;
      total++;
      if ({a_gnt, b_gnt, mem_mr} !== 3'b001) $display("FAIL rr_access_%0d: got %b expected 001", k, {a_gnt, b_gnt, mem_mr});
      else passed++;
      @(negedge clk); #1;
      total++;
      if ({a_done, b_done} !== exp_v) $display("FAIL rr_done_%0d: got %b expected %b", k, {a_done, b_done}, exp_v);
      else passed++;
      total++;
      if ((a_rdata | b_rdata) !== 32'hDEADBEEF || (a_rdata & b_rdata) !== 32'h0)
        $display("FAIL rr_rdata_%0d: got a=%h b=%h expected deadbeef on one port only", k, a_rdata, b_rdata);
      else passed++;
      @(negedge clk);
      if (k == 3) begin a_req = 1'b0; b_req = 1'b0; end
      #1;
    end
  endtask

  task automatic test_illegal();
    bit gnt_ok; logic mr, mw, done, err, od; logic [31:0] rd;
    logic [31:0] addr_v [5] = '{32'h102, 32'h101, 32'h100, MEM_BYTES, MEM_BYTES - 4};
    logic [2:0]  f3_v   [5] = '{3'b010, 3'b001, 3'b100, 3'b010, 3'b010};
    bit          we_v   [5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    bit          port_v [5] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    bit          bad_v  [5] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    for (int i = 0; i < 5; i++) begin
      int s0;
      s0 = strobe_cnt;
      xact(port_v[i], we_v[i], addr_v[i], 32'hCAFEF00D, f3_v[i], gnt_ok, mr, mw, done, err, rd, od);
      total++;
      if ({gnt_ok, done, err, od} !== {3'b11, bad_v[i], 1'b0})
        $display("FAIL illegal_%0d_flags: got %b expected %b", i, {gnt_ok, done, err, od}, {3'b11, bad_v[i], 1'b0});
      else passed++;
      total++;
      if (rd !== 32'h0) $display("FAIL illegal_%0d_rdata: got %h expected 0", i, rd);
      else passed++;
      total++;
      if ((strobe_cnt - s0) !== (bad_v[i] ? 0 : 1))
        $display("FAIL illegal_%0d_strobes: got %0d expected %0d", i, strobe_cnt - s0, bad_v[i] ? 0 : 1);
      else passed++;
    end
  endtask

  task automatic test_signed_load();
    bit gnt_ok; logic mr, mw, done, err, od; logic [31:0] rd;
    xact(1'b1, 1'b1, 32'h200, 32'h00000080, 3'b000, gnt_ok, mr, mw, done, err, rd, od);
    total++;
    if ({gnt_ok, mw, done, err} !== 4'b1110) $display("FAIL sb_flags: got %b expected 1110", {gnt_ok, mw, done, err});
    else passed++;
    xact(1'b0, 1'b0, 32'h200, 32'h0, 3'b000, gnt_ok, mr, mw, done, err, rd, od);
    total++;
    if (rd !== 32'hFFFFFF80) $display("FAIL lb_rdata: got %h expected ffffff80", rd);
    else passed++;
    xact(1'b1, 1'b0, 32'h200, 32'h0, 3'b100, gnt_ok, mr, mw, done, err, rd, od);
    total++;
    if (rd !== 32'h00000080) $display("FAIL lbu_rdata: got %h expected 00000080", rd);
    else passed++;
  endtask

  task automatic test_reset_mid();
    bit gnt_ok; logic mr, mw, done, err, od; logic [31:0] rd;
    @(negedge clk);
    a_req = 1'b1; a_we = 1'b1; a_addr = 32'h300; a_wdata = 32'h12345678; a_funct3 = 3'b010;
    #1;
    total++;
    if (a_gnt !== 1'b1) $display("FAIL rst_mid_gnt: got %b expected 1", a_gnt);
    else passed++;
    @(negedge clk);             // ACCESS cycle, reset asserted
    rst_n = 1'b0;
    #1;
    total++;
    if (mem_mw !== 1'b0) $display("FAIL rst_mid_mw: got %b expected 0", mem_mw);
    else passed++;
    @(negedge clk); #1;         // reset has taken effect; a_req still high
    total++;
    if ({busy, a_done, b_done, a_gnt} !== 4'b0000)
      $display("FAIL rst_mid_state: got %b expected 0000", {busy, a_done, b_done, a_gnt});
    else passed++;
    a_req = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    xact(1'b0, 1'b0, 32'h300, 32'h0, 3'b010, gnt_ok, mr, mw, done, err, rd, od);
    total++;
    if ({gnt_ok, done, rd} !== {2'b11, 32'h0}) $display("FAIL rst_mid_load: got done=%b rdata=%h expected 1 00000000", done, rd);
    else passed++;
  endtask

  task automatic test_late_request();
    int s0, o0;
    s0 = strobe_cnt; o0 = overlap_cnt;
    @(negedge clk);
    a_req = 1'b1; a_we = 1'b0; a_addr = 32'h100; a_funct3 = 3'b010;
    #1;
    total++;
    if ({a_gnt, b_gnt} !== 2'b10) $display("FAIL late_a_gnt: got %b expected 10", {a_gnt, b_gnt});
    else passed++;
    @(negedge clk);             // A in ACCESS, B starts requesting
    a_req = 1'b0;
    b_req = 1'b1; b_we = 1'b0; b_addr = 32'h200; b_funct3 = 3'b010;
    #1;
    total++;
    if (b_gnt !== 1'b0) $display("FAIL late_b_in_access: got %b expected 0", b_gnt);
    else passed++;
    @(negedge clk); #1;         // A in DONE
    total++;
    if ({a_done, b_gnt} !== 2'b10) $display("FAIL late_b_in_done: got %b expected 10", {a_done, b_gnt});
    else passed++;
    @(negedge clk); #1;         // first IDLE after A
    total++;
    if (b_gnt !== 1'b1) $display("FAIL late_b_gnt: got %b expected 1", b_gnt);
    else passed++;
    @(negedge clk);
    b_req = 1'b0;
    @(negedge clk); #1;         // B in DONE
    total++;
    if ({b_done, b_rdata} !== {1'b1, 32'h00000080}) $display("FAIL late_b_done: got %b %h expected 1 00000080", b_done, b_rdata);
    else passed++;
    total++;
    if ((strobe_cnt - s0) !== 2 || overlap_cnt !== o0)
      $display("FAIL late_strobes: got %0d strobes %0d overlaps expected 2 and 0", strobe_cnt - s0, overlap_cnt - o0);
    else passed++;
  endtask

  initial begin
    test_reset();
    test_store_load();
    test_simultaneous();
    test_illegal();
    test_signed_load();
    test_reset_mid();
    test_late_request();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

endmodule
